// File: rtl/audio_tone_analyzer.sv
// audio_tone_analyzer: measures period and peaks of an audio stream, one full
// cycle at a time, using rising crossings with hysteresis.
// Optional feature macro: TONE_ANALYZER_DC_EN adds the dc_offset output.
module audio_tone_analyzer #(
    parameter logic signed [15:0] HYST       = 16'sd256,
    parameter int                 PERIOD_W   = 16,
    parameter int                 MAX_PERIOD = 65535
) (
    input  logic                       clk_audio,
    input  logic                       reset_n,
    input  logic                       sample_valid,
    input  logic signed [15:0]         level,
    output logic                       result_valid,
    output logic        [PERIOD_W-1:0] period,
    output logic signed [15:0]         peak_pos,
    output logic signed [15:0]         peak_neg,
    output logic                       locked,
`ifdef TONE_ANALYZER_DC_EN
    output logic                       timeout,
    output logic signed [15:0]         dc_offset
`else
    output logic                       timeout
`endif
);

    localparam logic signed [15:0]  NEG_HYST = -HYST;
    localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

    typedef enum logic [1:0] {ARM, SYNC, HIGH, LOW} state_t;

    state_t               state;
    logic [PERIOD_W-1:0]  cnt;
    logic signed [15:0]   run_max;
    logic signed [15:0]   run_min;

    logic                 is_high;
    logic                 is_low;
    logic                 at_max;

    function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [15:0] smin(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return (a < b) ? a : b;
    endfunction

`ifdef TONE_ANALYZER_DC_EN
    // Midpoint of the peaks; 17-bit sum cannot overflow, shift floors toward -inf.
    function automatic logic signed [15:0] dc_mid(input logic signed [15:0] hi,
                                                  input logic signed [15:0] lo);
        logic signed [16:0] sum;
        sum = {hi[15], hi} + {lo[15], lo};
        return sum[16:1];
    endfunction
`endif

    // Hysteresis thresholds and counter limit, all signed compares on the sample.
    always_comb begin
        is_high = (level >= HYST);
        is_low  = (level <= NEG_HYST);
        at_max  = (cnt == MAX_CNT);
    end

    // Crossing FSM with running period counter, peak tracking and registered results.
    always_ff @(posedge clk_audio) begin
        if (!reset_n) begin
            state        <= ARM;
            cnt          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            period       <= '0;
            peak_pos     <= '0;
            peak_neg     <= '0;
            locked       <= 1'b0;
`ifdef TONE_ANALYZER_DC_EN
            dc_offset    <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (sample_valid) begin
                case (state)
                    ARM: begin
                        if (is_low) state <= SYNC;
                    end
                    SYNC: begin
                        if (is_high) begin
                            state   <= HIGH;
                            cnt     <= CNT_ONE;
                            run_max <= level;
                            run_min <= level;
                        end
                    end
                    HIGH: begin
                        if (at_max) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            cnt     <= '0;
                            state   <= ARM;
                        end else begin
                            cnt     <= cnt + CNT_ONE;
                            run_max <= smax(run_max, level);
                            run_min <= smin(run_min, level);
                            if (is_low) state <= LOW;
                        end
                    end
                    LOW: begin
                        if (is_high) begin
                            // Completing crossing: the crossing sample opens the next cycle.
                            result_valid <= 1'b1;
                            locked       <= 1'b1;
                            period       <= cnt;
                            peak_pos     <= run_max;
                            peak_neg     <= run_min;
`ifdef TONE_ANALYZER_DC_EN
                            dc_offset    <= dc_mid(run_max, run_min);
`endif
                            cnt          <= CNT_ONE;
                            run_max      <= level;
                            run_min      <= level;
                            state        <= HIGH;
                        end else if (at_max) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            cnt     <= '0;
                            state   <= ARM;
                        end else begin
                            cnt     <= cnt + CNT_ONE;
                            run_max <= smax(run_max, level);
                            run_min <= smin(run_min, level);
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_tone_analyzer.sv
// tb_audio_tone_analyzer: randomized and directed stimulus against a
// history-based reference model, for a default instance and one with MAX_PERIOD=100.
module tb_audio_tone_analyzer;

    localparam int H     = 256;
    localparam int MAXP0 = 65535;
    localparam int MAXP1 = 100;

    logic               clk_audio = 1'b0;
    logic               reset_n;
    logic               sample_valid;
    logic signed [15:0] level;

    logic               rv0, lk0, to0, rv1, lk1, to1;
    logic        [15:0] per0, per1;
    logic signed [15:0] pp0, pn0, pp1, pn1;
`ifdef TONE_ANALYZER_DC_EN
    logic signed [15:0] dc0, dc1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rv_count = 0;

    // Reference model state (index 0: default instance, 1: short-timeout instance)
    int hist[$];
    int m_seen[2], m_rise[2], m_below[2], m_ridx[2];
    int e_rv[2], e_to[2], e_per[2], e_pp[2], e_pn[2], e_lk[2], e_dc[2];

    always #5 clk_audio = ~clk_audio;

    audio_tone_analyzer dut (
        .clk_audio(clk_audio), .reset_n(reset_n), .sample_valid(sample_valid),
        .level(level), .result_valid(rv0), .period(per0), .peak_pos(pp0),
        .peak_neg(pn0), .locked(lk0),
`ifdef TONE_ANALYZER_DC_EN
        .dc_offset(dc0),
`endif
        .timeout(to0)
    );

    audio_tone_analyzer #(.MAX_PERIOD(MAXP1)) dut_t (
        .clk_audio(clk_audio), .reset_n(reset_n), .sample_valid(sample_valid),
        .level(level), .result_valid(rv1), .period(per1), .peak_pos(pp1),
        .peak_neg(pn1), .locked(lk1),
`ifdef TONE_ANALYZER_DC_EN
        .dc_offset(dc1),
`endif
        .timeout(to1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seen[i] = 0; m_rise[i] = 0; m_below[i] = 0; m_ridx[i] = 0;
            e_rv[i] = 0; e_to[i] = 0; e_per[i] = 0; e_pp[i] = 0; e_pn[i] = 0;
            e_lk[i] = 0; e_dc[i] = 0;
        end
    endtask

    // One valid sample s at history index n: a cycle spans from one rising
    // event up to (excluding) the next rising event that follows a low excursion.
    task automatic model_step(input int i, input int maxp, input int s, input int n);
        int len, mx, mn;
        e_rv[i] = 0;
        e_to[i] = 0;
        if (m_rise[i] == 0) begin
            if (m_seen[i] == 0) begin
                if (s <= -H) m_seen[i] = 1;
            end else if (s >= H) begin
                m_rise[i]  = 1;
                m_ridx[i]  = n;
                m_below[i] = 0;
            end
        end else begin
            len = n - m_ridx[i];
            if (m_below[i] != 0 && s >= H) begin
                mx = hist[m_ridx[i]];
                mn = hist[m_ridx[i]];
                for (int k = m_ridx[i]; k < n; k++) begin
                    if (hist[k] > mx) mx = hist[k];
                    if (hist[k] < mn) mn = hist[k];
                end
                e_rv[i]  = 1;
                e_lk[i]  = 1;
                e_per[i] = len;
                e_pp[i]  = mx;
                e_pn[i]  = mn;
                e_dc[i]  = (mx + mn) >>> 1;
                m_ridx[i]  = n;
                m_below[i] = 0;
            end else if (len == maxp) begin
                e_to[i]   = 1;
                e_lk[i]   = 0;
                m_rise[i] = 0;
                m_seen[i] = 0;
            end else if (s <= -H) begin
                m_below[i] = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("i0.result_valid", int'(rv0), e_rv[0]);
        check_eq("i0.timeout",      int'(to0), e_to[0]);
        check_eq("i0.locked",       int'(lk0), e_lk[0]);
        check_eq("i0.period",       int'(per0), e_per[0]);
        check_eq("i0.peak_pos",     int'(pp0), e_pp[0]);
        check_eq("i0.peak_neg",     int'(pn0), e_pn[0]);
        check_eq("i1.result_valid", int'(rv1), e_rv[1]);
        check_eq("i1.timeout",      int'(to1), e_to[1]);
        check_eq("i1.locked",       int'(lk1), e_lk[1]);
        check_eq("i1.period",       int'(per1), e_per[1]);
        check_eq("i1.peak_pos",     int'(pp1), e_pp[1]);
        check_eq("i1.peak_neg",     int'(pn1), e_pn[1]);
`ifdef TONE_ANALYZER_DC_EN
        check_eq("i0.dc_offset",    int'(dc0), e_dc[0]);
        check_eq("i1.dc_offset",    int'(dc1), e_dc[1]);
`endif
    endtask

    // Drive one clock with the given inputs, advance the model, check #1 after the edge.
    task automatic cycle(input bit v, input int s, input bit rn);
        int n;
        sample_valid = v;
        level        = 16'(s);
        reset_n      = rn;
        @(posedge clk_audio);
        if (!rn) begin
            model_reset();
        end else if (v) begin
            n = hist.size();
            model_step(0, MAXP0, s, n);
            model_step(1, MAXP1, s, n);
            hist.push_back(s);
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_rv[i] = 0;
                e_to[i] = 0;
            end
        end
        #1;
        if (rv0) rv_count++;
        check_outputs();
    endtask

    function automatic int garbage();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic square(input int ap, input int an, input int half, input int ncyc,
                          input bit toggle);
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 2 * half; k++) begin
                cycle(1'b1, (k < half) ? ap : an, 1'b1);
                if (toggle) cycle(1'b0, garbage(), 1'b1);
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        rv_count = 0;
    endtask

    initial begin
        int to_idx, sgn, half, bl, amp;
        real two_pi;
        two_pi = 6.283185307179586;
        model_reset();

        // Reset state
        do_reset();
        check_eq("reset.locked", int'(lk0), 0);
        check_eq("reset.period", int'(per0), 0);
        check_eq("reset.peak_pos", int'(pp0), 0);

        // Square wave +/-1000, 8+8 samples
        square(1000, -1000, 8, 5, 1'b0);
        check_eq("sq.result_count", rv_count, 3);
        check_eq("sq.period", int'(per0), 16);
        check_eq("sq.peak_pos", int'(pp0), 1000);
        check_eq("sq.peak_neg", int'(pn0), -1000);
        check_eq("sq.locked", int'(lk0), 1);

        // Sine, 1024 samples per cycle
        do_reset();
        for (int k = 0; k < 4 * 1024; k++)
            cycle(1'b1, int'(30000.0 * $sin(two_pi * real'(k % 1024) / 1024.0)), 1'b1);
        check_eq("sine.period", int'(per0), 1024);
        check_eq("sine.peak_pos", int'(pp0), 30000);
        check_eq("sine.peak_neg", int'(pn0), -30000);

        // Square with sub-threshold noise bursts mid-phase
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int ph = 0; ph < 2; ph++) begin
                sgn = (ph == 0) ? 1 : -1;
                for (int k = 0; k < 4; k++) cycle(1'b1, sgn * 1000, 1'b1);
                bl = int'($urandom_range(1, 6));
                for (int k = 0; k < bl; k++)
                    cycle(1'b1, int'($urandom_range(0, 400)) - 200, 1'b1);
                for (int k = 0; k < 4; k++) cycle(1'b1, sgn * 1000, 1'b1);
            end
        end
        check_eq("noise.result_count", rv_count, 3);

        // Half-rate: sample_valid toggling on square data
        do_reset();
        square(1000, -1000, 8, 5, 1'b1);
        check_eq("half.result_count", rv_count, 3);
        check_eq("half.period", int'(per0), 16);

        // Timeout on the MAX_PERIOD=100 instance
        do_reset();
        square(1000, -1000, 8, 2, 1'b0);
        to_idx = -1;
        for (int k = 0; k < 130; k++) begin
            cycle(1'b1, 1000, 1'b1);
            if (to1 && to_idx < 0) to_idx = k;
        end
        check_eq("tmo.index", to_idx, 100);
        check_eq("tmo.locked", int'(lk1), 0);
        check_eq("tmo.period_held", int'(per1), 16);

        // Mid-cycle reset discards the measurement
        do_reset();
        square(1000, -1000, 8, 3, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1000, 1'b1);
        cycle(1'b1, 1000, 1'b0);
        check_eq("midrst.locked", int'(lk0), 0);
        check_eq("midrst.period", int'(per0), 0);
        rv_count = 0;
        square(1000, -1000, 8, 2, 1'b0);
        check_eq("midrst.no_early_result", rv_count, 0);
        square(1000, -1000, 8, 1, 1'b0);
        check_eq("midrst.first_result", rv_count, 1);

        // Full-scale extremes
        do_reset();
        square(32767, -32768, 8, 3, 1'b0);
        check_eq("ext.peak_pos", int'(pp0), 32767);
        check_eq("ext.peak_neg", int'(pn0), -32768);
`ifdef TONE_ANALYZER_DC_EN
        check_eq("ext.dc_offset", int'(dc0), -1);
        do_reset();
        square(1500, -500, 8, 3, 1'b0);
        check_eq("dc.offset", int'(dc0), 500);
`endif

        // Randomized segments: varying lengths, amplitudes, gaps, noise, resets
        do_reset();
        for (int seg = 0; seg < 240; seg++) begin
            half = int'($urandom_range(1, 70));
            sgn  = (seg % 2 == 0) ? 1 : -1;
            for (int k = 0; k < half; k++) begin
                if ($urandom_range(0, 7) == 0) amp = garbage();
                else amp = sgn * int'($urandom_range(150, 3000));
                cycle($urandom_range(0, 3) != 0, amp, 1'b1);
            end
            if ($urandom_range(0, 59) == 0) cycle(1'b1, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
